// File: rtl/item_spawn_scheduler.sv
// Collects freed-block events from both players, buffers them, rolls a spawn
// chance per event and hands winners round-robin to the three item generators.
module item_spawn_scheduler #(
  parameter int          NUM_ROW    = 11,
  parameter int          NUM_COL    = 15,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_1234,
  localparam int         ADDR_WIDTH = $clog2(NUM_ROW*NUM_COL),
  localparam int         LVL_W      = $clog2(FIFO_DEPTH) + 1,
  localparam int         PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  game_over,
  input  logic [1:0]            req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr_p1,
  input  logic [ADDR_WIDTH-1:0] req_addr_p2,
  input  logic [31:0]           probability,
  input  logic [2:0]            item_active,
  output logic [2:0]            gen_we,
  output logic [ADDR_WIDTH-1:0] gen_addr,
  output logic                  busy,
  output logic [LVL_W-1:0]      fifo_level,
  output logic [7:0]            drop_count
);

  typedef enum logic [1:0] {S_IDLE, S_ROLL, S_PICK, S_ISSUE} state_t;

  state_t                state_reg, state_next;
  logic [31:0]           lfsr_reg, lfsr_next;
  logic [ADDR_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]      level_reg;
  logic                  prio_reg;
  logic [1:0]            tp_reg, sel_reg;
  logic [ADDR_WIDTH-1:0] addr_reg, gen_addr_reg;
  logic [7:0]            drop_reg, drop_next;

  // Galois form of x^32+x^22+x^2+x+1, shifting right
  assign lfsr_next = {1'b0, lfsr_reg[31:1]} ^ (lfsr_reg[0] ? 32'h8020_0003 : 32'h0);

  // Order the cycle's requests: when both fire, the priority requester goes first
  logic                  first_valid, second_valid, wr0, wr1, pop;
  logic [ADDR_WIDTH-1:0] first_addr, second_addr;
  logic [LVL_W-1:0]      free_space, n_enq;

  always_comb begin
    first_valid  = 1'b0;
    second_valid = 1'b0;
    first_addr   = req_addr_p1;
    second_addr  = req_addr_p2;
    if (req_valid == 2'b11) begin
      first_valid  = 1'b1;
      second_valid = 1'b1;
      first_addr   = prio_reg ? req_addr_p2 : req_addr_p1;
      second_addr  = prio_reg ? req_addr_p1 : req_addr_p2;
    end else if (req_valid == 2'b01) begin
      first_valid = 1'b1;
    end else if (req_valid == 2'b10) begin
      first_valid = 1'b1;
      first_addr  = req_addr_p2;
    end
  end

  assign free_space = LVL_W'(FIFO_DEPTH) - level_reg;
  assign wr0        = first_valid  && (free_space >= LVL_W'(1));
  assign wr1        = second_valid && (free_space >= LVL_W'(2));
  assign n_enq      = LVL_W'(wr0) + LVL_W'(wr1);
  assign pop        = (state_reg == S_IDLE) && (level_reg != '0);

  // Candidate types in scan order starting at the type pointer
  logic [1:0] cand_idx [3];
  logic [2:0] cand_free;
  for (genvar gi = 0; gi < 3; gi++) begin : g_cand
    logic [2:0] sum;
    assign sum           = {1'b0, tp_reg} + 3'(gi);
    assign cand_idx[gi]  = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    assign cand_free[gi] = ~item_active[cand_idx[gi]];
  end

  logic       found, pick_drop;
  logic [1:0] pick_sel, drop_inc;
  logic [8:0] drop_sum;

  assign found     = |cand_free;
  assign pick_sel  = cand_free[0] ? cand_idx[0] : (cand_free[1] ? cand_idx[1] : cand_idx[2]);
  assign pick_drop = (state_reg == S_PICK) && !found;
  assign drop_inc  = 2'(first_valid && !wr0) + 2'(second_valid && !wr1) + 2'(pick_drop);
  assign drop_sum  = {1'b0, drop_reg} + 9'(drop_inc);
  assign drop_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (level_reg != '0) state_next = S_ROLL;
      S_ROLL:  state_next = (lfsr_reg <= probability) ? S_PICK : S_IDLE;
      S_PICK:  state_next = found ? S_ISSUE : S_IDLE;
      S_ISSUE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_reg <= LFSR_SEED;
    else     lfsr_reg <= lfsr_next;
  end

  // Buffer storage carries no reset; pointers and level define validity
  always_ff @(posedge clk) begin
    if (wr0) mem[wr_ptr_reg] <= first_addr;
    if (wr1) mem[wr_ptr_reg + PTR_W'(1)] <= second_addr;
    if (pop) addr_reg <= mem[rd_ptr_reg];
  end

  always_ff @(posedge clk) begin
    if (rst || game_over) begin
      state_reg    <= S_IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      prio_reg     <= 1'b0;
      tp_reg       <= 2'd0;
      sel_reg      <= 2'd0;
      gen_addr_reg <= '0;
      if (rst) drop_reg <= 8'd0;
    end else begin
      state_reg  <= state_next;
      wr_ptr_reg <= wr_ptr_reg + PTR_W'(n_enq);
      rd_ptr_reg <= rd_ptr_reg + PTR_W'(pop);
      level_reg  <= level_reg + n_enq - LVL_W'(pop);
      drop_reg   <= drop_next;
      if (req_valid == 2'b11) prio_reg <= ~prio_reg;
      if (state_reg == S_PICK && found) begin
        sel_reg      <= pick_sel;
        gen_addr_reg <= addr_reg;
      end
      if (state_reg == S_ISSUE) tp_reg <= (sel_reg == 2'd2) ? 2'd0 : sel_reg + 2'd1;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_we
    assign gen_we[gi] = (state_reg == S_ISSUE) && (sel_reg == 2'(gi));
  end

  assign gen_addr   = gen_addr_reg;
  assign busy       = (state_reg != S_IDLE) || (level_reg != '0);
  assign fifo_level = level_reg;
  assign drop_count = drop_reg;

endmodule

// File: tb/tb_item_spawn_scheduler.sv
// Randomised bench: an event-level reference model predicts every spawn write
// and the status outputs; a negedge monitor compares the DUT against it.
module tb_item_spawn_scheduler;
  localparam int NR    = 11;
  localparam int NC    = 15;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(NR*NC);
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] SEED = 32'hACE1_1234;

  logic          clk = 1'b0;
  logic          rst, game_over;
  logic [1:0]    req_valid;
  logic [AW-1:0] req_addr_p1, req_addr_p2;
  logic [31:0]   probability;
  logic [2:0]    item_active;
  logic [2:0]    gen_we;
  logic [AW-1:0] gen_addr;
  logic          busy;
  logic [LW-1:0] fifo_level;
  logic [7:0]    drop_count;

  item_spawn_scheduler #(.NUM_ROW(NR), .NUM_COL(NC), .FIFO_DEPTH(DEPTH), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .game_over(game_over), .req_valid(req_valid),
    .req_addr_p1(req_addr_p1), .req_addr_p2(req_addr_p2), .probability(probability),
    .item_active(item_active), .gen_we(gen_we), .gen_addr(gen_addr), .busy(busy),
    .fifo_level(fifo_level), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [2:0]    we;
    logic [AW-1:0] addr;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int passed = 0;
  int cyc    = 0;
  bit chk_en = 0;

  // Reference model: the queue holds buffered addresses, m_stage counts the
  // cycles an event spends being processed (0 waiting, 1 roll, 2 pick, 3 issue)
  logic [AW-1:0] m_q[$];
  logic [31:0]   m_lfsr;
  int            m_stage, m_prio, m_tp, m_sel, m_drops;
  logic [AW-1:0] m_cur, m_gaddr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] lfsr_adv(input logic [31:0] l);
    logic [31:0] taps;
    taps = (32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1;
    return l[0] ? ((l >> 1) ^ taps) : (l >> 1);
  endfunction

  task automatic model_step();
    int free;
    int old_level;
    logic [AW-1:0] order[$];
    cyc++;
    if (rst) begin
      m_q.delete(); m_stage = 0; m_prio = 0; m_tp = 0; m_sel = 0;
      m_drops = 0; m_gaddr = '0; m_lfsr = SEED;
      return;
    end
    if (game_over) begin
      m_q.delete(); m_stage = 0; m_prio = 0; m_tp = 0; m_sel = 0;
      m_gaddr = '0; m_lfsr = lfsr_adv(m_lfsr);
      return;
    end
    old_level = m_q.size();
    case (m_stage)
      0: if (old_level > 0) begin m_cur = m_q.pop_front(); m_stage = 1; end
      1: m_stage = (m_lfsr <= probability) ? 2 : 0;
      2: begin
        m_stage = 0;
        m_drops++;
        for (int k = 0; k < 3; k++) begin
          int idx;
          idx = (m_tp + k) % 3;
          if (m_stage == 0 && !item_active[idx]) begin
            m_sel = idx; m_stage = 3; m_drops--;
          end
        end
        if (m_stage == 3) begin
          m_gaddr = m_cur;
          exp_q.push_back('{cyc: cyc, we: 3'(1 << m_sel), addr: m_cur});
        end
      end
      default: begin m_tp = (m_sel + 1) % 3; m_stage = 0; end
    endcase
    if (req_valid == 2'b11) begin
      if (m_prio == 0) begin order.push_back(req_addr_p1); order.push_back(req_addr_p2); end
      else             begin order.push_back(req_addr_p2); order.push_back(req_addr_p1); end
      m_prio = 1 - m_prio;
    end else if (req_valid == 2'b01) order.push_back(req_addr_p1);
    else if (req_valid == 2'b10)     order.push_back(req_addr_p2);
    free = DEPTH - old_level;
    foreach (order[i]) begin
      if (free > 0) begin m_q.push_back(order[i]); free--; end
      else m_drops++;
    end
    if (m_drops > 255) m_drops = 255;
    m_lfsr = lfsr_adv(m_lfsr);
  endtask

  // Monitor: status outputs every cycle, write strobes against the scoreboard
  always @(negedge clk) begin
    if (chk_en) begin
      chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
      chk("drop_count", 32'(drop_count), 32'(m_drops));
      chk("busy", 32'(busy), 32'((m_stage != 0) || (m_q.size() != 0)));
      chk("gen_addr", 32'(gen_addr), 32'(m_gaddr));
      if (gen_we != 3'b000) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_gen_we", 32'(gen_we), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("issue cycle %0d: gen_we=%b gen_addr=%0d (expected cycle %0d we=%b addr=%0d)",
                   cyc, gen_we, gen_addr, e.cyc, e.we, e.addr);
          chk("issue_cycle", 32'(cyc), 32'(e.cyc));
          chk("issue_we", 32'(gen_we), 32'(e.we));
          chk("issue_addr", 32'(gen_addr), 32'(e.addr));
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        chk("missing_gen_we", 32'(gen_we), 32'(exp_q[0].we));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 2'b00;
    repeat (n) tick();
  endtask

  task automatic req(input logic [1:0] v, input int a1, input int a2);
    req_valid   = v;
    req_addr_p1 = AW'(a1);
    req_addr_p2 = AW'(a2);
    tick();
    req_valid = 2'b00;
  endtask

  initial begin
    rst = 1'b1; game_over = 1'b0; req_valid = 2'b00;
    req_addr_p1 = '0; req_addr_p2 = '0;
    probability = 32'hFFFF_FFFF; item_active = 3'b000;
    @(negedge clk);
    tick(); tick();
    chk("reset_gen_we", 32'(gen_we), 32'd0);
    chk("reset_gen_addr", 32'(gen_addr), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_fifo_level", 32'(fifo_level), 32'd0);
    chk("reset_drop_count", 32'(drop_count), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Basic issue and round-robin
    idle(2);
    req(2'b01, 17, 0); idle(7);
    req(2'b01, 3, 0);  idle(3);
    req(2'b01, 9, 0);  idle(3);
    req(2'b10, 0, 21); idle(3);
    req(2'b01, 30, 0); idle(6);

    // Skip active generators, then none free
    item_active = 3'b011;
    req(2'b01, 40, 0); idle(6);
    item_active = 3'b111;
    req(2'b01, 41, 0); idle(6);
    item_active = 3'b000;

    // Overflow with simultaneous requests, spawns disabled
    probability = 32'h0;
    req(2'b11, 50, 51); req(2'b11, 52, 53); req(2'b11, 54, 55);
    idle(20);

    // Probability gate
    for (int i = 0; i < 10; i++) begin
      req(2'b01, 60 + i, 0); idle(5);
    end

    // Flush during a roll with entries still buffered
    probability = 32'hFFFF_FFFF;
    req(2'b11, 70, 71); req(2'b11, 72, 73);
    game_over = 1'b1; tick(); game_over = 1'b0;
    req(2'b01, 80, 0); idle(8);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0) begin
        case ($urandom_range(0, 3))
          0:       probability = 32'h0;
          1:       probability = 32'hFFFF_FFFF;
          default: probability = $urandom;
        endcase
      end
      if (i % 16 == 0) item_active = 3'($urandom_range(0, 7));
      req_valid   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      req_addr_p1 = AW'($urandom_range(0, NR*NC-1));
      req_addr_p2 = AW'($urandom_range(0, NR*NC-1));
      game_over   = ($urandom_range(0, 79) == 0);
      rst         = (i == 700);
      tick();
    end
    rst = 1'b0; game_over = 1'b0;
    idle(20);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
